// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time.
// It synchronizes the rows, picks one candidate key per full scan, debounces
// that candidate over consecutive scans, and then commits a registered hex
// key code together with a valid level and a one-cycle press pulse.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SCAN_TICKS - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    // Column scan state and dwell counter
    col_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    // Row synchronizer
    logic [3:0] row_meta_q, row_sync_q;

    // Candidate accumulated over the current scan
    logic       scan_hit_q, scan_hit_d;
    logic [3:0] scan_code_q, scan_code_d;

    // Previous scan's candidate and how many scans it has repeated
    logic              cand_hit_q, cand_hit_d;
    logic [3:0]        cand_code_q, cand_code_d;
    logic [STAB_W-1:0] stable_q, stable_d;

    // Committed outputs
    logic       key_valid_q, key_valid_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_press_q, key_press_d;

    // Per-cycle decode signals
    logic       sample;
    logic       end_of_scan;
    logic       col_hit;
    logic [3:0] col_code;
    logic       now_hit;
    logic [3:0] now_code;
    logic       commit;

    // Saturating increment of the stable-scan count.
    function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] v);
        logic [STAB_W-1:0] r;
        if (v >= STAB_MAX) begin
            r = STAB_MAX;
        end else begin
            r = v + STAB_W'(1);
        end
        return r;
    endfunction

    // Index of the topmost low row; only meaningful when some row is low.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0]) begin
            r = 2'd0;
        end else if (!rows[1]) begin
            r = 2'd1;
        end else if (!rows[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    // Physical key position (row, column) to the hex code printed on the key.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous rows; resets to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column state register and dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COL0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // Column next-state: advance one column after each full dwell.
    always_comb begin
        sample  = (tick_q == LAST_TICK);
        state_d = state_q;
        tick_d  = tick_q + TICK_W'(1);
        if (sample) begin
            tick_d = '0;
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                default: state_d = COL0;
            endcase
        end
        end_of_scan = sample && (state_q == COL3);
    end

    // Drive exactly one column low, selected by the scan state.
    always_comb begin
        col = ~(4'b0001 << state_q);
    end

    // Candidate selection: the first key found in a scan wins (left column,
    // then top row); later columns cannot displace it.
    always_comb begin
        col_hit     = ~&row_sync_q;
        col_code    = key_lookup(first_low_row(row_sync_q), state_q);
        now_hit     = scan_hit_q;
        now_code    = scan_code_q;
        if (!scan_hit_q && col_hit) begin
            now_hit  = 1'b1;
            now_code = col_code;
        end
        scan_hit_d  = scan_hit_q;
        scan_code_d = scan_code_q;
        if (sample) begin
            if (end_of_scan) begin
                scan_hit_d  = 1'b0;
                scan_code_d = 4'h0;
            end else begin
                scan_hit_d  = now_hit;
                scan_code_d = now_code;
            end
        end
    end

    // Debounce: count consecutive identical scan candidates; any change restarts.
    always_comb begin
        cand_hit_d  = cand_hit_q;
        cand_code_d = cand_code_q;
        stable_d    = stable_q;
        if (end_of_scan) begin
            if ((now_hit == cand_hit_q) && (now_code == cand_code_q)) begin
                stable_d = sat_inc(stable_q);
            end else begin
                stable_d    = STAB_W'(1);
                cand_hit_d  = now_hit;
                cand_code_d = now_code;
            end
        end
        commit = end_of_scan && (stable_d == STAB_MAX);
    end

    // Commit logic: outputs change only when a candidate has been stable long
    // enough; press fires only for a newly held or different key.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_press_d = 1'b0;
        if (commit) begin
            key_valid_d = now_hit;
            key_code_d  = now_hit ? now_code : 4'h0;
            key_press_d = now_hit && (!key_valid_q || (now_code != key_code_q));
        end
    end

    // Scan, debounce and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_hit_q  <= 1'b0;
            scan_code_q <= 4'h0;
            cand_hit_q  <= 1'b0;
            cand_code_q <= 4'h0;
            stable_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_press_q <= 1'b0;
        end else begin
            scan_hit_q  <= scan_hit_d;
            scan_code_q <= scan_code_d;
            cand_hit_q  <= cand_hit_d;
            cand_code_q <= cand_code_d;
            stable_q    <= stable_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_press_q <= key_press_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_press = key_press_q;

endmodule
